gold_interaction_ctrl: RTL and testbench
========================================

Name: gold_interaction_ctrl

Overview:
Per-gold-bag interaction arbiter: the initiator side of the gold mover's event inputs. Once per frame it evaluates digger/gold contact, gold state and the dirt map cell below the bag. It then drives the mover's collision/side, can_fall and been_eaten inputs, plus score and digger-kill events to game control. One instance sits beside each gold mover, between the pixel collision detector, the dirt-map RAM and the mover.

Parameters:
CELL_LOG2, 5, log2 of cell size in pixels (32-px cells)
NUM_ROWS, 10, playfield rows; row NUM_ROWS-1 is the floor
MAP_TIMEOUT, 15, max cycles waiting for map_rd_valid
DIR_RIGHT/DIR_LEFT/DIR_VERT, 1/2/3, digger_dir encodings; 0 = stopped

Ports:
clk  in  1  clock
resetN  in  1  async active-low reset
startOfFrame  in  1  one-cycle pulse per frame
digger_gold_hit  in  1  pixel overlap digger/this gold (any cycle)
digger_dir  in  2  digger motion direction
digger_topLeftX  in  11 signed  digger position
digger_topLeftY  in  11 signed  digger position
gold_topLeftX  in  11 signed  gold position (from mover)
gold_topLeftY  in  11 signed  gold position
gold_state  in  4  0 rest/moving, 1 falling, 2 crashed, 3 eaten
map_rd_req  out  1  one-cycle dirt-map read request
map_rd_col  out  6  cell column
map_rd_row  out  6  cell row
map_rd_valid  in  1  read data valid
map_rd_data  in  1  1 = dirt present, 0 = tunnel
collision  out  1  one-cycle push pulse to mover
side  out  1  0 pushed from left, 1 from right
can_fall  out  1  level: cell below empty
been_eaten  out  1  level, sticky
score_pulse  out  1  one-cycle: gold collected
digger_killed  out  1  one-cycle: falling gold hit digger

Behaviour:
- Reset: all outputs 0; FSM S_IDLE; hit latch 0; timeout counter 0.
- Hit latch: OR of digger_gold_hit between frames. In the startOfFrame cycle, the latch is copied to hit_frame and then cleared. A hit coincident with startOfFrame goes into the new latch, not hit_frame.
- side: combinational, registered in S_EVAL. side = 1 iff digger_topLeftX > gold_topLeftX (signed compare).
- FSM, one pass per frame:
  - S_IDLE: on startOfFrame, take snapshot, go S_REQ.
  - S_REQ: row = gold_topLeftY[10:5], col = gold_topLeftX[10:5].
    - If gold_topLeftY is negative or row >= NUM_ROWS-1: skip read, set below_empty = 0, go S_EVAL.
    - Otherwise: map_rd_req = 1 for one cycle, with map_rd_col = col and map_rd_row = row+1; go S_WAIT.
  - S_WAIT: on map_rd_valid, set below_empty = ~map_rd_data and go S_EVAL. After MAP_TIMEOUT cycles with no valid, set below_empty = 0 and go S_EVAL. Late valids are ignored.
  - S_EVAL: one cycle, update outputs, then go S_IDLE.
- S_EVAL rules, using gold_state sampled in S_EVAL:
  - state 0:
    - can_fall <= below_empty.
    - collision pulses if hit_frame and ((dir=RIGHT and side=0) or (dir=LEFT and side=1)). A push takes priority over the fall decision inside the mover.
  - state 1:
    - can_fall <= below_empty.
    - If hit_frame and digger_topLeftY > gold_topLeftY: digger_killed pulses. No collision pulse.
  - state 2:
    - can_fall <= 0.
    - If hit_frame and been_eaten = 0: been_eaten <= 1 and score_pulse pulses, exactly once.
  - state 3: all pulses suppressed; been_eaten stays 1.
- can_fall is held stable between S_EVAL cycles. collision, score_pulse and digger_killed are high only in the S_EVAL cycle.
- A startOfFrame arriving while not in S_IDLE is not lost: it sets a pending flag, and S_IDLE starts immediately on the next cycle. At most one pending frame is kept.
- resetN low mid-query returns to S_IDLE with all outputs 0 and the request dropped.

Decomposition:
- Package gold_pkg holds:
  - the gold_state encodings (REST, FALLING, CRASHED, EATEN);
  - the digger_dir encodings;
  - CELL_LOG2;
  - the FSM state enum.
- Optional sub-module gold_map_query: wraps S_REQ/S_WAIT and the timeout, returns below_empty plus a done strobe.

Test Plan:
- Gold at (64,96), state 0, digger at (32,96) with dir=RIGHT, hit for 3 cycles mid-frame -> at S_EVAL after next startOfFrame: collision = 1 for one cycle, side = 0, map_rd_row = 4, map_rd_col = 2.
- Gold at (64,96), state 0, map returns data = 0 two cycles after req -> can_fall = 1 three cycles after S_REQ and held until the next S_EVAL. Next frame data = 1 -> can_fall = 0.
- Gold at row NUM_ROWS-1 (Y=288) -> no map_rd_req; can_fall = 0.
- Map never responds -> S_EVAL after 15 wait cycles; can_fall = 0; a valid arriving later is ignored.
- Gold state 2 with hit -> been_eaten = 1 and score_pulse for exactly one cycle. Hits in further frames produce no second score_pulse.
- Gold state 1 at Y=96, digger at Y=128 with hit -> digger_killed pulse, collision = 0. Assert resetN low during S_WAIT -> all outputs 0 and FSM in S_IDLE.

Source files
------------

// File: rtl/gold_pkg.sv
// Shared types and constants for the gold-bag interaction arbiter.
package gold_pkg;

  // Pixel coordinate width and the cell geometry derived from it.
  localparam int COORD_W   = 11;
  localparam int CELL_LOG2 = 5;
  localparam int CELL_W    = COORD_W - CELL_LOG2;

  // Gold mover state as reported back by the mover.
  typedef enum logic [3:0] {
    GOLD_REST    = 4'd0,
    GOLD_FALLING = 4'd1,
    GOLD_CRASHED = 4'd2,
    GOLD_EATEN   = 4'd3
  } gold_state_e;

  // Digger motion direction encodings.
  localparam logic [1:0] DIR_STOP  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_VERT  = 2'd3;

  // One evaluation pass per frame.
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL
  } ctrl_state_e;

endpackage

// File: rtl/gold_map_query.sv
// Dirt-map lookup of the cell directly below the gold bag. Issues a single
// read request (or skips it when the bag is above the playfield or on the
// floor row), waits a bounded number of cycles for the answer and reports
// the result with a one-cycle done strobe.
module gold_map_query
  import gold_pkg::*;
#(
  parameter int NUM_ROWS    = 10,
  parameter int MAP_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic              y_neg,
  input  logic [CELL_W-1:0] cell_row,
  input  logic [CELL_W-1:0] cell_col,
  output logic              map_rd_req,
  output logic [CELL_W-1:0] map_rd_col,
  output logic [CELL_W-1:0] map_rd_row,
  input  logic              map_rd_valid,
  input  logic              map_rd_data,
  output logic              done,
  output logic              below_empty
);

  localparam int                CNT_W     = $clog2(MAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAP_TIMEOUT - 1);
  localparam logic [CELL_W-1:0] FLOOR_ROW = CELL_W'(NUM_ROWS - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             skip;

  // Request issue, response capture and timeout; valids seen while not busy are dropped.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    skip        = y_neg || (cell_row >= FLOOR_ROW);
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    below_empty = 1'b0;
    map_rd_req  = 1'b0;
    map_rd_col  = '0;
    map_rd_row  = '0;

    if (busy_q) begin
      if (map_rd_valid) begin
        done        = 1'b1;
        below_empty = ~map_rd_data;
        busy_d      = 1'b0;
        cnt_d       = '0;
      end else if (cnt_q == CNT_LAST) begin
        // Map never answered: treat the cell as solid so the bag stays put.
        done   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (start) begin
      if (skip) begin
        done = 1'b1;
      end else begin
        map_rd_req = 1'b1;
        map_rd_col = cell_col;
        map_rd_row = cell_row + CELL_W'(1);
        busy_d     = 1'b1;
        cnt_d      = '0;
      end
    end
  end

  // Busy flag and wait counter.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: async active-low reset puts every flop in a known state
    // immediately, even mid-query, so a stale request can never complete.
    if (!resetN) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from pre-edge values.
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/gold_interaction_ctrl.sv
// Per-gold-bag interaction arbiter. Once per frame it snapshots digger
// contact, looks up the dirt cell below the bag and then, in a single
// evaluation cycle, drives the mover's push/fall/eaten inputs and the
// score and digger-kill events for game control.
module gold_interaction_ctrl
  import gold_pkg::*;
#(
  parameter int NUM_ROWS    = 10,
  parameter int MAP_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      digger_gold_hit,
  input  logic [1:0]                digger_dir,
  input  logic signed [COORD_W-1:0] digger_topLeftX,
  input  logic signed [COORD_W-1:0] digger_topLeftY,
  input  logic signed [COORD_W-1:0] gold_topLeftX,
  input  logic signed [COORD_W-1:0] gold_topLeftY,
  input  logic [3:0]                gold_state,
  output logic                      map_rd_req,
  output logic [CELL_W-1:0]         map_rd_col,
  output logic [CELL_W-1:0]         map_rd_row,
  input  logic                      map_rd_valid,
  input  logic                      map_rd_data,
  output logic                      collision,
  output logic                      side,
  output logic                      can_fall,
  output logic                      been_eaten,
  output logic                      score_pulse,
  output logic                      digger_killed
);

  ctrl_state_e state_q, state_d;

  logic hit_latch_q, hit_latch_d;
  logic hit_frame_q, hit_frame_d;
  logic pending_q, pending_d;
  logic pending_hit_q, pending_hit_d;
  logic below_empty_q, below_empty_d;
  logic can_fall_q, can_fall_d;
  logic side_q, side_d;
  logic been_eaten_q, been_eaten_d;

  logic q_start;
  logic q_done;
  logic q_below;
  logic side_now;
  logic digger_below;

  // Digger right of the bag means it pushes from the right; a digger lower
  // on screen than a falling bag is underneath it.
  assign side_now     = digger_topLeftX > gold_topLeftX;
  assign digger_below = digger_topLeftY > gold_topLeftY;
  assign q_start      = (state_q == S_REQ);

  gold_map_query #(
    .NUM_ROWS    (NUM_ROWS),
    .MAP_TIMEOUT (MAP_TIMEOUT)
  ) u_map_query (
    .clk          (clk),
    .resetN       (resetN),
    .start        (q_start),
    .y_neg        (gold_topLeftY[COORD_W-1]),
    .cell_row     (gold_topLeftY[COORD_W-1:CELL_LOG2]),
    .cell_col     (gold_topLeftX[COORD_W-1:CELL_LOG2]),
    .map_rd_req   (map_rd_req),
    .map_rd_col   (map_rd_col),
    .map_rd_row   (map_rd_row),
    .map_rd_valid (map_rd_valid),
    .map_rd_data  (map_rd_data),
    .done         (q_done),
    .below_empty  (q_below)
  );

  // Hit latch, pending-frame bookkeeping, next state and evaluation outputs.
  always_comb begin
    state_d       = state_q;
    hit_frame_d   = hit_frame_q;
    pending_d     = pending_q;
    pending_hit_d = pending_hit_q;
    below_empty_d = below_empty_q;
    can_fall_d    = can_fall_q;
    side_d        = side_q;
    been_eaten_d  = been_eaten_q;
    collision     = 1'b0;
    score_pulse   = 1'b0;
    digger_killed = 1'b0;

    // A hit in the frame-start cycle belongs to the frame that is starting.
    hit_latch_d = startOfFrame ? digger_gold_hit : (hit_latch_q | digger_gold_hit);

    // A frame start while busy is remembered (only one) with its contact snapshot.
    if (startOfFrame && (state_q != S_IDLE)) begin
      pending_d     = 1'b1;
      pending_hit_d = pending_hit_q | hit_latch_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (startOfFrame || pending_q) begin
          hit_frame_d   = (startOfFrame & hit_latch_q) | (pending_q & pending_hit_q);
          pending_d     = 1'b0;
          pending_hit_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (q_done) begin
          below_empty_d = q_below;
          state_d       = S_EVAL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (q_done) begin
          below_empty_d = q_below;
          state_d       = S_EVAL;
        end
      end
      S_EVAL: begin
        side_d  = side_now;
        state_d = S_IDLE;
        case (gold_state)
          GOLD_REST: begin
            can_fall_d = below_empty_q;
            collision  = hit_frame_q &&
                         (((digger_dir == DIR_RIGHT) && !side_now) ||
                          ((digger_dir == DIR_LEFT)  &&  side_now));
          end
          GOLD_FALLING: begin
            can_fall_d    = below_empty_q;
            digger_killed = hit_frame_q && digger_below;
          end
          GOLD_CRASHED: begin
            can_fall_d = 1'b0;
            if (hit_frame_q && !been_eaten_q) begin
              been_eaten_d = 1'b1;
              score_pulse  = 1'b1;
            end
          end
          default: begin
            can_fall_d = 1'b0;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Level outputs show the new value already in the evaluation cycle and hold after.
  assign can_fall   = can_fall_d;
  assign side       = side_d;
  assign been_eaten = been_eaten_d;

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      hit_latch_q   <= 1'b0;
      hit_frame_q   <= 1'b0;
      pending_q     <= 1'b0;
      pending_hit_q <= 1'b0;
      below_empty_q <= 1'b0;
      can_fall_q    <= 1'b0;
      side_q        <= 1'b0;
      been_eaten_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hit_latch_q   <= hit_latch_d;
      hit_frame_q   <= hit_frame_d;
      pending_q     <= pending_d;
      pending_hit_q <= pending_hit_d;
      below_empty_q <= below_empty_d;
      can_fall_q    <= can_fall_d;
      side_q        <= side_d;
      been_eaten_q  <= been_eaten_d;
    end
  end

endmodule

// File: tb/tb_gold_interaction_ctrl.sv
// Self-checking bench for gold_interaction_ctrl. Each driven cycle pushes the
// expected output vector to a scoreboard queue; a negedge monitor pops and
// compares. Reset behaviour is checked inline.
module tb_gold_interaction_ctrl;
  import gold_pkg::*;

  localparam int NUM_ROWS = 10;

  logic              clk;
  logic              resetN;
  logic              sof;
  logic              hit;
  logic [1:0]        dir;
  logic signed [10:0] dx, dy, gx, gy;
  logic [3:0]        gstate;
  logic              map_rd_req;
  logic [5:0]        map_rd_col, map_rd_row;
  logic              map_rd_valid, map_rd_data;
  logic              collision, side, can_fall, been_eaten, score_pulse, digger_killed;

  gold_interaction_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (sof),
    .digger_gold_hit (hit),
    .digger_dir      (dir),
    .digger_topLeftX (dx),
    .digger_topLeftY (dy),
    .gold_topLeftX   (gx),
    .gold_topLeftY   (gy),
    .gold_state      (gstate),
    .map_rd_req      (map_rd_req),
    .map_rd_col      (map_rd_col),
    .map_rd_row      (map_rd_row),
    .map_rd_valid    (map_rd_valid),
    .map_rd_data     (map_rd_data),
    .collision       (collision),
    .side            (side),
    .can_fall        (can_fall),
    .been_eaten      (been_eaten),
    .score_pulse     (score_pulse),
    .digger_killed   (digger_killed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic [5:0] row;
    logic [5:0] col;
    logic       coll;
    logic       side;
    logic       cf;
    logic       be;
    logic       score;
    logic       kill;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Bench model of the held outputs.
  logic m_cf, m_side, m_be;

  function automatic obs_t idle_exp();
    obs_t e;
    e      = '0;
    e.side = m_side;
    e.cf   = m_cf;
    e.be   = m_be;
    return e;
  endfunction

  task automatic push(input obs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected vector per driven cycle.
  always @(negedge clk) begin
    obs_t  e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {map_rd_req, map_rd_row, map_rd_col, collision, side, can_fall,
           been_eaten, score_pulse, digger_killed};
      n_checks++;
      if (a !== e)
        $display("FAIL %s @%0t: got req=%b row=%0d col=%0d coll=%b side=%b can_fall=%b eaten=%b score=%b killed=%b; expected req=%b row=%0d col=%0d coll=%b side=%b can_fall=%b eaten=%b score=%b killed=%b",
                 t, $time, a.req, a.row, a.col, a.coll, a.side, a.cf, a.be, a.score, a.kill,
                 e.req, e.row, e.col, e.coll, e.side, e.cf, e.be, e.score, e.kill);
      else
        n_pass++;
    end
  end

  // One full frame: optional pre-hits, frame start, lookup, evaluation, hold cycle.
  // delay_i = cycles after the request at which the map answers (0 = never).
  task automatic run_frame(input int gx_i, input int gy_i, input int dx_i, input int dy_i,
                           input logic [1:0] dir_i, input logic [3:0] st_i, input logic hit_i,
                           input int delay_i, input logic data_i, input logic late_i,
                           input logic from_pending, input int sof_in_wait, input string name);
    obs_t e;
    logic skip, below, side_n, hit_eff;
    int   nw;
    hit_eff = from_pending ? 1'b0 : hit_i;
    if (!from_pending) begin
      for (int i = 0; i < 3; i++) begin
        step();
        gx = 11'(gx_i); gy = 11'(gy_i); dx = 11'(dx_i); dy = 11'(dy_i);
        dir = dir_i; gstate = st_i; hit = hit_i; map_rd_valid = 1'b0;
        push(idle_exp(), {name, "_pre"});
      end
      step();
      hit = 1'b0;
      sof = 1'b1;
      push(idle_exp(), {name, "_sof"});
    end
    step();
    gx = 11'(gx_i); gy = 11'(gy_i); dx = 11'(dx_i); dy = 11'(dy_i);
    dir = dir_i; gstate = st_i; sof = 1'b0; hit = 1'b0; map_rd_valid = 1'b0;
    skip = (gy_i < 0) || ((gy_i / 32) >= NUM_ROWS - 1);
    e = idle_exp();
    if (!skip) begin
      e.req = 1'b1;
      e.row = 6'((gy_i / 32) + 1);
      e.col = 6'(gx_i / 32);
    end
    push(e, {name, "_req"});
    below = 1'b0;
    if (!skip) begin
      nw = (delay_i == 0) ? 15 : delay_i;
      for (int w = 1; w <= nw; w++) begin
        step();
        map_rd_valid = (delay_i != 0) && (w == delay_i);
        map_rd_data  = data_i;
        sof          = (w == sof_in_wait);
        push(idle_exp(), {name, "_wait"});
      end
      if (delay_i != 0) below = ~data_i;
    end
    step();
    map_rd_valid = 1'b0;
    sof          = 1'b0;
    side_n = dx_i > gx_i;
    e      = '0;
    case (st_i)
      4'd0: begin
        m_cf   = below;
        e.coll = hit_eff && (((dir_i == 2'd1) && !side_n) || ((dir_i == 2'd2) && side_n));
      end
      4'd1: begin
        m_cf   = below;
        e.kill = hit_eff && (dy_i > gy_i);
      end
      4'd2: begin
        m_cf = 1'b0;
        if (hit_eff && !m_be) begin
          m_be    = 1'b1;
          e.score = 1'b1;
        end
      end
      default: m_cf = 1'b0;
    endcase
    m_side = side_n;
    e.side = m_side;
    e.cf   = m_cf;
    e.be   = m_be;
    push(e, {name, "_eval"});
    step();
    map_rd_valid = late_i;
    map_rd_data  = 1'b0;
    push(idle_exp(), {name, "_hold"});
  endtask

  task automatic check_all_zero(input string name);
    logic [19:0] o;
    @(negedge clk);
    o = {map_rd_req, map_rd_row, map_rd_col, collision, side, can_fall,
         been_eaten, score_pulse, digger_killed};
    n_checks++;
    if (o !== 20'b0)
      $display("FAIL %s: got outputs=%b, expected all zero", name, o);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      sof = (i == 1);
      hit = 1'b1;
      check_all_zero("reset_hold");
    end
    step();
    sof = 1'b0;
    hit = 1'b0;
    resetN = 1'b1;
    m_cf = 1'b0; m_side = 1'b0; m_be = 1'b0;
    check_all_zero("reset_release");
  endtask

  task automatic test_push();
    run_frame(64, 96, 32, 96, DIR_RIGHT, 4'd0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0, "push_right");
    run_frame(64, 96, 96, 96, DIR_LEFT,  4'd0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0, "push_left");
    run_frame(64, 96, 96, 96, DIR_RIGHT, 4'd0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 0, "push_wrong_way");
  endtask

  task automatic test_fall();
    run_frame(64, 96, 200, 96, DIR_STOP, 4'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0, "fall_empty");
    run_frame(64, 96, 200, 96, DIR_STOP, 4'd0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0, "fall_dirt");
    run_frame(64, 96, 200, 96, DIR_STOP, 4'd0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0, "fall_empty_d3");
  endtask

  task automatic test_floor();
    run_frame(64, 288, 200, 96, DIR_STOP, 4'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0, "floor_row");
    run_frame(64, 256, 200, 96, DIR_STOP, 4'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0, "above_floor");
    run_frame(64, -32, 200, 96, DIR_STOP, 4'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0, "negative_y");
  endtask

  task automatic test_timeout();
    run_frame(128, 64, 200, 96, DIR_STOP, 4'd0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0, "pre_timeout");
    run_frame(128, 64, 200, 96, DIR_STOP, 4'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, "timeout");
    run_frame(128, 64, 200, 96, DIR_STOP, 4'd0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0, "post_timeout");
  endtask

  task automatic test_back_to_back();
    run_frame(64, 96, 32, 96, DIR_RIGHT, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3, "busy_sof");
    run_frame(64, 96, 32, 96, DIR_RIGHT, 4'd0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 0, "pending_frame");
  endtask

  task automatic test_eaten();
    run_frame(64, 96, 32, 96, DIR_RIGHT, 4'd2, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, "eaten_first");
    run_frame(64, 96, 32, 96, DIR_RIGHT, 4'd2, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, "eaten_again");
    run_frame(64, 96, 32, 96, DIR_RIGHT, 4'd3, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, "state_eaten");
  endtask

  task automatic test_kill_and_reset();
    obs_t e;
    run_frame(64, 96, 32, 128, DIR_RIGHT, 4'd1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, "kill");
    // Frame interrupted by reset while waiting on the map.
    step();
    gstate = 4'd0; dy = 11'sd96; hit = 1'b0; map_rd_valid = 1'b0;
    push(idle_exp(), "rst_pre");
    step();
    sof = 1'b1;
    push(idle_exp(), "rst_sof");
    step();
    sof = 1'b0;
    e = idle_exp();
    e.req = 1'b1; e.row = 6'd4; e.col = 6'd2;
    push(e, "rst_req");
    step();
    push(idle_exp(), "rst_wait");
    step();
    resetN = 1'b0;
    check_all_zero("reset_mid_query");
    step();
    map_rd_valid = 1'b1;
    map_rd_data  = 1'b0;
    check_all_zero("reset_mid_query_hold");
    step();
    map_rd_valid = 1'b0;
    resetN = 1'b1;
    m_cf = 1'b0; m_side = 1'b0; m_be = 1'b0;
    check_all_zero("reset_mid_release");
    run_frame(64, 96, 32, 96, DIR_RIGHT, 4'd0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, "after_reset");
  endtask

  initial begin
    sof = 1'b0; hit = 1'b0; dir = 2'd0; gstate = 4'd0;
    dx = '0; dy = '0; gx = '0; gy = '0;
    map_rd_valid = 1'b0; map_rd_data = 1'b0;
    m_cf = 1'b0; m_side = 1'b0; m_be = 1'b0;
    test_reset();
    test_push();
    test_fall();
    test_floor();
    test_timeout();
    test_back_to_back();
    test_eaten();
    test_kill_and_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
